// File: rtl/memory_initiator_pkg.sv
// Shared definitions for the memory_initiator burst sequencer.
// Command direction encoding is common to every block that builds burst commands.
package memory_initiator_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/memory_initiator_stream_reg.sv
// One-deep registered stb/rdy slice; accepts a new word whenever empty or being drained.
module stream_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_s_stb,
    input  logic [WIDTH-1:0] i_s_dat,
    output logic             o_s_rdy,
    output logic             o_m_stb,
    output logic [WIDTH-1:0] o_m_dat,
    input  logic             i_m_rdy
);

    logic             r_stb;
    logic [WIDTH-1:0] r_dat;

    assign o_s_rdy = ~r_stb | i_m_rdy;
    assign o_m_stb = r_stb;
    assign o_m_dat = r_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb <= 1'b0;
            r_dat <= '0;
        end else if (i_s_stb && o_s_rdy) begin
            r_stb <= 1'b1;
            r_dat <= i_s_dat;
        end else if (i_m_rdy) begin
            r_stb <= 1'b0;
        end
    end

endmodule

// File: rtl/memory_initiator.sv
// Burst sequencer: drains a stream into consecutive memory words, or fetches
// consecutive words onto a stream, one burst command at a time.
module memory_initiator
    import memory_initiator_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_stb,
    input  logic             cmd_we,
    input  logic [AW-1:0]    cmd_adr,
    input  logic [AW-1:0]    cmd_len,
    output logic             cmd_rdy,
    input  logic             s_stb,
    input  logic [WIDTH-1:0] s_dat,
    output logic             s_rdy,
    output logic             m_stb,
    output logic [WIDTH-1:0] m_dat,
    input  logic             m_rdy,
    output logic             aw_stb,
    output logic [AW-1:0]    aw_dat,
    input  logic             aw_rdy,
    output logic             w_stb,
    output logic [WIDTH-1:0] w_dat,
    input  logic             w_rdy,
    output logic             ar_stb,
    output logic [AW-1:0]    ar_dat,
    input  logic             ar_rdy,
    input  logic             r_stb,
    input  logic [WIDTH-1:0] r_dat,
    output logic             r_rdy,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_adr;
    logic [AW-1:0] r_rem;
    logic [AW-1:0] r_rcv;
    logic          r_ar_stb;
    logic          r_busy;
    logic          r_done;

    logic w_in_write;
    logic w_wr_hs;
    logic w_ar_hs;
    logic w_m_hs;

    // Explicit wrap keeps bursts correct for non-power-of-two depths.
    function automatic logic [AW-1:0] adr_inc(input logic [AW-1:0] a);
        if (a == AW'(DEPTH - 1)) begin
            return '0;
        end
        return a + 1'b1;
    endfunction

    assign w_in_write = (r_state == S_WRITE);
    assign cmd_rdy    = (r_state == S_IDLE);

    assign aw_stb = w_in_write & s_stb;
    assign w_stb  = w_in_write & s_stb;
    assign aw_dat = r_adr;
    assign w_dat  = s_dat;
    assign s_rdy  = w_in_write & aw_rdy & w_rdy;

    assign ar_stb = r_ar_stb;
    assign ar_dat = r_adr;

    assign w_wr_hs = s_stb & s_rdy;
    assign w_ar_hs = r_ar_stb & ar_rdy;
    assign w_m_hs  = m_stb & m_rdy;

    assign busy = r_busy;
    assign done = r_done;

    stream_reg #(
        .WIDTH (WIDTH)
    ) u_m_slice (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_s_stb (r_stb),
        .i_s_dat (r_dat),
        .o_s_rdy (r_rdy),
        .o_m_stb (m_stb),
        .o_m_dat (m_dat),
        .i_m_rdy (m_rdy)
    );

    // Issue (r_rem) and completion (r_rcv) are counted separately on reads so
    // the burst only ends once the last word has left the output slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_adr    <= '0;
            r_rem    <= '0;
            r_rcv    <= '0;
            r_ar_stb <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_stb) begin
                        r_adr    <= cmd_adr;
                        r_rem    <= cmd_len;
                        r_rcv    <= cmd_len;
                        r_busy   <= 1'b1;
                        r_ar_stb <= (cmd_we == CMD_READ);
                        r_state  <= (cmd_we == CMD_WRITE) ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    if (w_wr_hs) begin
                        r_adr <= adr_inc(r_adr);
                        if (r_rem == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_rem <= r_rem - 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (w_ar_hs) begin
                        r_adr <= adr_inc(r_adr);
                        if (r_rem == '0) begin
                            r_ar_stb <= 1'b0;
                        end else begin
                            r_rem <= r_rem - 1'b1;
                        end
                    end
                    if (w_m_hs) begin
                        if (r_rcv == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_rcv <= r_rcv - 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_initiator.sv
// Randomized bench for memory_initiator: a behavioural memory, a reference word
// array and expected-transfer queues built from each burst command.
module tb_memory_initiator;

    localparam int WIDTH = 16;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_stb, cmd_we, cmd_rdy;
    logic [AW-1:0]    cmd_adr, cmd_len;
    logic             s_stb, s_rdy;
    logic [WIDTH-1:0] s_dat;
    logic             m_stb, m_rdy;
    logic [WIDTH-1:0] m_dat;
    logic             aw_stb, aw_rdy;
    logic [AW-1:0]    aw_dat;
    logic             w_stb, w_rdy;
    logic [WIDTH-1:0] w_dat;
    logic             ar_stb, ar_rdy;
    logic [AW-1:0]    ar_dat;
    logic             r_stb, r_rdy;
    logic [WIDTH-1:0] r_dat;
    logic             busy, done;

    always #5 clk = ~clk;

    memory_initiator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_stb(cmd_stb), .cmd_we(cmd_we), .cmd_adr(cmd_adr), .cmd_len(cmd_len), .cmd_rdy(cmd_rdy),
        .s_stb(s_stb), .s_dat(s_dat), .s_rdy(s_rdy),
        .m_stb(m_stb), .m_dat(m_dat), .m_rdy(m_rdy),
        .aw_stb(aw_stb), .aw_dat(aw_dat), .aw_rdy(aw_rdy),
        .w_stb(w_stb), .w_dat(w_dat), .w_rdy(w_rdy),
        .ar_stb(ar_stb), .ar_dat(ar_dat), .ar_rdy(ar_rdy),
        .r_stb(r_stb), .r_dat(r_dat), .r_rdy(r_rdy),
        .busy(busy), .done(done)
    );

    function automatic logic [WIDTH-1:0] init_word(input int i);
        return WIDTH'(i * 257) ^ 16'h5A5A;
    endfunction

    // Attached memory: one-deep registered read port, writes on aw & w.
    logic [WIDTH-1:0] mem [DEPTH];
    logic             mr_full;
    logic [WIDTH-1:0] mr_dat;

    assign ar_rdy = ~mr_full | r_rdy;
    assign r_stb  = mr_full;
    assign r_dat  = mr_dat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mr_full <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else begin
            if (aw_stb && aw_rdy && w_stb && w_rdy) mem[aw_dat] <= w_dat;
            if (ar_stb && ar_rdy) begin
                mr_full <= 1'b1;
                mr_dat  <= mem[ar_dat];
            end else if (r_rdy) begin
                mr_full <= 1'b0;
            end
        end
    end

    int               n_chk = 0;
    int               n_fail = 0;
    int               cyc = 0;
    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic [WIDTH-1:0] src_q [$];
    int               exp_adr [$];
    logic [WIDTH-1:0] exp_dat [$];
    int               aw_pct = 100, w_pct = 100, m_pct = 100, src_pct = 100;
    bit               cmd_pend = 0, cmd_hold = 0, p_we = 0;
    int               p_adr = 0, p_len = 0;
    bit               hs_cmd = 0, hs_s = 0, m_stall = 0;
    logic [WIDTH-1:0] m_hold_dat = '0;
    int               n_cmd = 0, n_ar = 0, n_m = 0, n_done = 0, last_xfer = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, observe the coming handshakes 4ns later.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (hs_s) s_stb = 1'b0;
        if (!s_stb && src_q.size() > 0 && $urandom_range(0, 99) < src_pct) begin
            s_dat = src_q.pop_front();
            s_stb = 1'b1;
        end
        if (hs_cmd && !cmd_hold) cmd_stb = 1'b0;
        if (cmd_pend) begin
            cmd_stb  = 1'b1;
            cmd_we   = p_we;
            cmd_adr  = AW'(p_adr);
            cmd_len  = AW'(p_len);
            cmd_pend = 0;
        end
        aw_rdy = ($urandom_range(0, 99) < aw_pct);
        w_rdy  = ($urandom_range(0, 99) < w_pct);
        m_rdy  = ($urandom_range(0, 99) < m_pct);
        #4;
        hs_cmd = cmd_stb && cmd_rdy;
        if (hs_cmd) n_cmd++;
        hs_s = s_stb && s_rdy;
        if (m_stall) chk("m_hold", 32'({m_stb, m_dat}), 32'({1'b1, m_hold_dat}));
        if (hs_s) begin
            last_xfer = cyc;
            if (exp_adr.size() == 0) chk("wr_extra", 32'(1), 32'(0));
            else begin
                chk("aw_dat", 32'(aw_dat), exp_adr.pop_front());
                chk("w_dat", 32'(w_dat), 32'(exp_dat.pop_front()));
                chk("aw_w_stb", 32'({aw_stb, w_stb}), 32'(3));
            end
        end
        if (m_stb && m_rdy) begin
            last_xfer = cyc;
            n_m++;
            if (exp_dat.size() == 0) chk("rd_extra", 32'(1), 32'(0));
            else chk("m_dat", 32'(m_dat), 32'(exp_dat.pop_front()));
        end
        m_stall    = m_stb && !m_rdy;
        m_hold_dat = m_dat;
        if (ar_stb && ar_rdy) begin
            n_ar++;
            chk("outstanding", 32'((n_ar - n_m) <= 2), 32'(1));
        end
        if (s_rdy)  chk("s_rdy_mode", 32'({busy, p_we}), 32'(3));
        if (ar_stb) chk("ar_mode", 32'({busy, p_we}), 32'(2));
        if (done) begin
            n_done++;
            chk("done_busy", 32'({busy, cmd_rdy}), 32'(0));
            chk("done_lat", 32'(cyc - last_xfer), 32'(1));
        end
    endtask

    // Expected transfers come from the command alone: address (adr+i) mod DEPTH.
    task automatic plan_burst(input bit we, input int adr, input int len, input int dbase, input bit issue);
        p_we = we; p_adr = adr; p_len = len; cmd_pend = issue;
        n_ar = 0; n_m = 0;
        for (int i = 0; i <= len; i++) begin
            int a;
            logic [WIDTH-1:0] d;
            a = (adr + i) % DEPTH;
            if (we) begin
                d = (dbase < 0) ? WIDTH'($urandom) : WIDTH'(dbase + i);
                ref_mem[a] = d;
                src_q.push_back(d);
                exp_adr.push_back(a);
                exp_dat.push_back(d);
            end else begin
                exp_dat.push_back(ref_mem[a]);
            end
        end
    endtask

    task automatic finish_burst(input int len);
        int start;
        int k;
        start = n_done;
        k = 0;
        while (n_done == start && k < 3000) begin
            step();
            k++;
        end
        chk("done_seen", 32'(n_done - start), 32'(1));
        chk("exp_drained", 32'(exp_dat.size()), 32'(0));
        if (!p_we) chk("ar_count", 32'(n_ar), 32'(len + 1));
        exp_adr.delete(); exp_dat.delete(); src_q.delete();
        step();
        chk("idle_after", 32'({done, busy, cmd_rdy}), 32'(1));
    endtask

    task automatic set_pct(input int a, input int w, input int m, input int s);
        aw_pct = a; w_pct = w; m_pct = m; src_pct = s;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0;
        int k;
        rst_n = 1'b0; cmd_stb = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0;
        s_stb = 1'b0; s_dat = '0; m_rdy = 1'b0; aw_rdy = 1'b0; w_rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stb", 32'({aw_stb, w_stb, ar_stb, m_stb}), 32'(0));
        chk("rst_busy_done", 32'({busy, done}), 32'(0));
        chk("rst_dat", {m_dat, aw_dat, ar_dat}, 32'(0));
        chk("rst_rdy", 32'({cmd_rdy, s_rdy}), 32'(2));
        @(negedge clk) rst_n = 1'b1;

        set_pct(100, 100, 100, 100);
        plan_burst(1, 'h10, 3, 'hA000, 1);
        finish_burst(3);
        plan_burst(0, 'h10, 3, -1, 1);
        finish_burst(3);

        set_pct(100, 100, 50, 100);
        plan_burst(0, 'h30, 7, -1, 1);
        finish_burst(7);

        set_pct(60, 60, 60, 70);
        plan_burst(1, 'hFE, 2, -1, 1);
        finish_burst(2);
        plan_burst(0, 'hFE, 2, -1, 1);
        finish_burst(2);

        set_pct(100, 100, 70, 100);
        c0 = n_cmd;
        cmd_hold = 1;
        plan_burst(0, 'h20, 2, -1, 1);
        finish_burst(2);
        chk("cmd_after_done", 32'(hs_cmd), 32'(1));
        chk("cmd_accepts", 32'(n_cmd - c0), 32'(2));
        cmd_hold = 0;
        plan_burst(0, 'h20, 2, -1, 0);
        finish_burst(2);

        set_pct(100, 100, 100, 100);
        plan_burst(0, 'h40, 3, -1, 1);
        k = 0;
        while (n_m < 2 && k < 200) begin
            step();
            k++;
        end
        chk("pre_rst_words", 32'(n_m), 32'(2));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_m", 32'(m_stb), 32'(0));
        chk("rst_mid_ctl", 32'({busy, done, cmd_rdy}), 32'(1));
        chk("rst_mid_ar", 32'(ar_stb), 32'(0));
        exp_adr.delete(); exp_dat.delete(); src_q.delete();
        hs_cmd = 0; hs_s = 0; m_stall = 0; cmd_stb = 1'b0; s_stb = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        repeat (3) begin
            @(negedge clk);
            #4 chk("rst_no_done", 32'(done), 32'(0));
        end
        @(negedge clk) rst_n = 1'b1;
        plan_burst(0, 'h40, 3, -1, 1);
        finish_burst(3);

        plan_burst(1, 'h00, DEPTH - 1, -1, 1);
        finish_burst(DEPTH - 1);
        set_pct(100, 100, 80, 100);
        plan_burst(0, 'h80, DEPTH - 1, -1, 1);
        finish_burst(DEPTH - 1);

        for (int t = 0; t < 6; t++) begin
            bit we;
            int adr;
            int len;
            we  = 1'($urandom_range(0, 1));
            adr = int'($urandom_range(0, DEPTH - 1));
            len = int'($urandom_range(0, 15));
            set_pct(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                    int'($urandom_range(30, 100)), int'($urandom_range(30, 100)));
            plan_burst(we, adr, len, -1, 1);
            finish_burst(len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
